// File: rtl/channel_pattern_gen.sv
// -----------------------------------------------------------------------------
// channel_pattern_gen
// Test-pattern transmitter for one logic-analyzer channel. Packed 8-bit words
// holding four (CH_H, CH_L) pairs are accepted through a valid/ready handshake.
// They are then serialized onto CH_H/CH_L, one pair per sample slot, at a
// programmable rate. The byte packing matches the capture path: the oldest pair
// is in bits [1:0] and the newest pair is in bits [7:6].
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   en            run enable; 0 freezes the sample-rate counter (state kept)
//   flush         synchronous abort of buffered data, counter and outputs
//   decim         sample period minus one, in clk cycles
//   clr_underrun  clears the sticky underrun flag
//   pat/pat_vld   packed pattern word and its valid
//   pat_rdy       block can take a word (hold buffer empty)
//   CH_H/CH_L     emitted comparator levels
//   smpl_tick     one-cycle pulse when CH_H/CH_L take a new sample slot
//   underrun      sticky: a sample slot came with no data available
//   busy          hold buffer full or pairs still pending in the shifter
// -----------------------------------------------------------------------------
module channel_pattern_gen #(
    parameter int DECIM_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic [DECIM_W-1:0] decim,
    input  logic               clr_underrun,
    input  logic [7:0]         pat,
    input  logic               pat_vld,
    output logic               pat_rdy,
    output logic               CH_H,
    output logic               CH_L,
    output logic               smpl_tick,
    output logic               underrun,
    output logic               busy
);

    // Registered state
    logic [DECIM_W-1:0] cnt_r;
    logic [7:0]         hbuf_r;
    logic               hvld_r;
    logic [5:0]         sreg_r;       // up to three pending pairs, next one in [1:0]
    logic [1:0]         pcnt_r;
    logic               ch_h_r;
    logic               ch_l_r;
    logic               smpl_tick_r;
    logic               underrun_r;

    // Next-state values
    logic [DECIM_W-1:0] cnt_s;
    logic [7:0]         hbuf_s;
    logic               hvld_s;
    logic [5:0]         sreg_s;
    logic [1:0]         pcnt_s;
    logic               ch_h_s;
    logic               ch_l_s;
    logic               smpl_tick_s;
    logic               underrun_s;

    logic               tick_s;
    logic               accept_s;

    // Internal sample tick: only while running, in the cycle the counter reaches decim.
    // A counter already past a newly lowered decim runs on to the natural wrap.
    assign tick_s   = en && (cnt_r == decim);
    // The ready path depends on registers only, so pat_vld never feeds back into pat_rdy.
    assign accept_s = pat_vld && !hvld_r;

    // Next-state logic for the counter, the buffers and the output slot.
    always_comb begin
        cnt_s       = cnt_r;
        hbuf_s      = hbuf_r;
        hvld_s      = hvld_r;
        sreg_s      = sreg_r;
        pcnt_s      = pcnt_r;
        ch_h_s      = ch_h_r;
        ch_l_s      = ch_l_r;
        smpl_tick_s = 1'b0;
        underrun_s  = underrun_r;

        if (flush) begin
            // Abort everything in flight. The handshake is ignored and underrun is kept.
            cnt_s       = {DECIM_W{1'b0}};
            hvld_s      = 1'b0;
            pcnt_s      = 2'd0;
            ch_h_s      = 1'b0;
            ch_l_s      = 1'b0;
            smpl_tick_s = 1'b0;
        end else begin
            if (tick_s) begin
                cnt_s = {DECIM_W{1'b0}};
            end else if (en) begin
                cnt_s = cnt_r + DECIM_W'(1);
            end else begin
                cnt_s = cnt_r;
            end

            // An accept only happens when the hold buffer is empty. A tick that drains
            // the hold buffer therefore never coincides with an accept.
            if (accept_s) begin
                hbuf_s = pat;
                hvld_s = 1'b1;
            end else begin
                hbuf_s = hbuf_r;
            end

            if (tick_s) begin
                smpl_tick_s = 1'b1;
                if (pcnt_r != 2'd0) begin
                    ch_h_s = sreg_r[1];
                    ch_l_s = sreg_r[0];
                    sreg_s = {2'b00, sreg_r[5:2]};
                    pcnt_s = pcnt_r - 2'd1;
                    underrun_s = clr_underrun ? 1'b0 : underrun_r;
                end else if (hvld_r) begin
                    ch_h_s = hbuf_r[1];
                    ch_l_s = hbuf_r[0];
                    sreg_s = hbuf_r[7:2];
                    pcnt_s = 2'd3;
                    hvld_s = 1'b0;
                    underrun_s = clr_underrun ? 1'b0 : underrun_r;
                end else begin
                    // Starved slot: hold the last levels and flag it. Set beats clear.
                    underrun_s = 1'b1;
                end
            end else begin
                underrun_s = clr_underrun ? 1'b0 : underrun_r;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {DECIM_W{1'b0}};
            hbuf_r      <= 8'h00;
            hvld_r      <= 1'b0;
            sreg_r      <= 6'd0;
            pcnt_r      <= 2'd0;
            ch_h_r      <= 1'b0;
            ch_l_r      <= 1'b0;
            smpl_tick_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            hbuf_r      <= hbuf_s;
            hvld_r      <= hvld_s;
            sreg_r      <= sreg_s;
            pcnt_r      <= pcnt_s;
            ch_h_r      <= ch_h_s;
            ch_l_r      <= ch_l_s;
            smpl_tick_r <= smpl_tick_s;
            underrun_r  <= underrun_s;
        end
    end

    assign CH_H      = ch_h_r;
    assign CH_L      = ch_l_r;
    assign smpl_tick = smpl_tick_r;
    assign underrun  = underrun_r;
    assign pat_rdy   = !hvld_r;
    assign busy      = hvld_r || (pcnt_r != 2'd0);

endmodule

// File: tb/tb_channel_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_channel_pattern_gen
// Directed bench for channel_pattern_gen. Stimulus pushes the expected
// {CH_H, CH_L, underrun} for every sample slot into a queue. A monitor pops an
// entry and compares it on every smpl_tick. The monitor also checks the spacing
// between ticks whenever a fixed period is expected.
// -----------------------------------------------------------------------------
module tb_channel_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [15:0] decim;
    logic        clr_underrun;
    logic [7:0]  pat;
    logic        pat_vld;
    logic        pat_rdy;
    logic        CH_H;
    logic        CH_L;
    logic        smpl_tick;
    logic        underrun;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  sb[$];          // {H, L, underrun after the slot}
    logic [2:0]  exp_e;
    int          cyc = 0;
    int          last_tick = -1;
    int          exp_period = 0;

    channel_pattern_gen #(.DECIM_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .flush        (flush),
        .decim        (decim),
        .clr_underrun (clr_underrun),
        .pat          (pat),
        .pat_vld      (pat_vld),
        .pat_rdy      (pat_rdy),
        .CH_H         (CH_H),
        .CH_L         (CH_L),
        .smpl_tick    (smpl_tick),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w, input logic u);
        for (int i = 0; i < 4; i++) begin
            sb.push_back({w[2*i+1], w[2*i], u});
        end
    endtask

    task automatic push_pair(input logic h, input logic l, input logic u);
        sb.push_back({h, l, u});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Offer a word and wait (bounded) until it is taken.
    task automatic send(input logic [7:0] w);
        int n = 0;
        pat     = w;
        pat_vld = 1'b1;
        while (!pat_rdy && n < 200) begin
            step();
            n++;
        end
        if (!pat_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pat_rdy stuck at 0 for word %0h", w);
        end
        step();
        pat_vld = 1'b0;
    endtask

    // Wait on negedges (bounded) until at most n expected slots remain.
    task automatic wait_size(input int n);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() <= n) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() > n) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: %0d slots pending, wanted %0d", sb.size(), n);
        end
    endtask

    // Monitor: compare every emitted sample slot against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && smpl_tick) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got H=%0b L=%0b expected no tick", CH_H, CH_L);
            end else begin
                exp_e = sb.pop_front();
                check("pair", {30'd0, CH_H, CH_L}, {30'd0, exp_e[2:1]});
                check("underrun_at_tick", {31'd0, underrun}, {31'd0, exp_e[0]});
            end
            if (exp_period != 0 && last_tick >= 0) begin
                check("tick_period", cyc - last_tick, exp_period);
            end
            last_tick = cyc;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; decim = 16'd0;
        clr_underrun = 1'b0; pat = 8'h00; pat_vld = 1'b0;
        #2;
        check("rst_ch", {30'd0, CH_H, CH_L}, 32'd0);
        check("rst_rdy", {31'd0, pat_rdy}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_tick", {31'd0, smpl_tick}, 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        // decim=0, single word 0xE4, then one starved slot
        decim = 16'd0;
        do_flush();
        send(8'hE4);
        check("loaded_busy", {31'd0, busy}, 32'd1);
        push_word(8'hE4, 1'b0);
        push_pair(1'b1, 1'b1, 1'b1);
        exp_period = 1; last_tick = -1;
        en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk); #1;
        check("t2_drained", sb.size(), 32'd0);
        check("t2_underrun", {31'd0, underrun}, 32'd1);
        check("t2_hold", {30'd0, CH_H, CH_L}, 32'd3);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("t2_clr", {31'd0, underrun}, 32'd0);

        // decim=3, 0x1B then 0xE4 back-to-back, gapless
        decim = 16'd3;
        do_flush();
        send(8'h1B);
        push_word(8'h1B, 1'b0);
        push_word(8'hE4, 1'b0);
        exp_period = 4; last_tick = -1;
        en = 1'b1;
        send(8'hE4);
        wait_size(0);
        en = 1'b0;
        check("t3_underrun", {31'd0, underrun}, 32'd0);

        // backpressure, decim=1, three words with pat_vld held high
        decim = 16'd1;
        do_flush();
        send(8'h27);
        check("bp_rdy_full", {31'd0, pat_rdy}, 32'd0);
        check("bp_busy", {31'd0, busy}, 32'd1);
        push_word(8'h27, 1'b0);
        push_word(8'hB1, 1'b0);
        push_word(8'hD8, 1'b0);
        exp_period = 2; last_tick = -1;
        en = 1'b1;
        pat_vld = 1'b1;
        send(8'hB1);
        check("bp_rdy_after_accept", {31'd0, pat_rdy}, 32'd0);
        pat_vld = 1'b1;
        send(8'hD8);
        wait_size(0);
        en = 1'b0;
        check("bp_underrun", {31'd0, underrun}, 32'd0);

        // flush after two pairs of 0xFF, then 0x55
        do_flush();
        send(8'hFF);
        push_pair(1'b1, 1'b1, 1'b0);
        push_pair(1'b1, 1'b1, 1'b0);
        last_tick = -1;
        en = 1'b1;
        wait_size(0);
        flush = 1'b1;
        en = 1'b0;
        step();
        flush = 1'b0;
        check("fl_ch", {30'd0, CH_H, CH_L}, 32'd0);
        check("fl_busy", {31'd0, busy}, 32'd0);
        check("fl_rdy", {31'd0, pat_rdy}, 32'd1);
        check("fl_tick", {31'd0, smpl_tick}, 32'd0);
        send(8'h55);
        push_word(8'h55, 1'b0);
        last_tick = -1;
        en = 1'b1;
        wait_size(0);
        en = 1'b0;

        // en=0 for 10 clks mid-word, then resume, then underrun/clear race
        do_flush();
        exp_period = 0;
        send(8'h9C);
        push_word(8'h9C, 1'b0);
        en = 1'b1;
        wait_size(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pause_tick", {31'd0, smpl_tick}, 32'd0);
            check("pause_ch", {30'd0, CH_H, CH_L}, 32'd3);
        end
        #1;
        push_pair(1'b1, 1'b0, 1'b1);
        en = 1'b1;
        wait_size(0);
        en = 1'b0;
        check("ur_set", {31'd0, underrun}, 32'd1);
        push_pair(1'b1, 1'b0, 1'b1);
        en = 1'b1;
        clr_underrun = 1'b1;
        @(negedge clk); #1;
        check("ur_clr", {31'd0, underrun}, 32'd0);
        @(negedge clk); #1;
        en = 1'b0;
        clr_underrun = 1'b0;
        check("ur_set_wins", {31'd0, underrun}, 32'd1);
        check("ur_drained", sb.size(), 32'd0);

        // async reset mid-stream (underrun still set from above)
        do_flush();
        send(8'hE4);
        push_word(8'hE4, 1'b1);
        exp_period = 2; last_tick = -1;
        en = 1'b1;
        wait_size(2);
        check("pre_rst_ch", {30'd0, CH_H, CH_L}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ch", {30'd0, CH_H, CH_L}, 32'd0);
        check("arst_rdy", {31'd0, pat_rdy}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_underrun", {31'd0, underrun}, 32'd0);
        sb.delete();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
